// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | aes_pkg - shared AES widths, FSM state type and counter sizing.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte-group counter width; a single group still needs one bit.
  function automatic int cnt_width(input int bpc);
    int groups;
    groups = AES_BYTES / bpc;
    return (groups <= 1) ? 1 : $clog2(groups);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sbox.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_sbox - 8-bit combinational AES inverse S-box lookup.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h52; 8'h01: out_byte = 8'h09; 8'h02: out_byte = 8'h6a; 8'h03: out_byte = 8'hd5; 8'h04: out_byte = 8'h30; 8'h05: out_byte = 8'h36; 8'h06: out_byte = 8'ha5; 8'h07: out_byte = 8'h38;
      8'h08: out_byte = 8'hbf; 8'h09: out_byte = 8'h40; 8'h0a: out_byte = 8'ha3; 8'h0b: out_byte = 8'h9e; 8'h0c: out_byte = 8'h81; 8'h0d: out_byte = 8'hf3; 8'h0e: out_byte = 8'hd7; 8'h0f: out_byte = 8'hfb;
      8'h10: out_byte = 8'h7c; 8'h11: out_byte = 8'he3; 8'h12: out_byte = 8'h39; 8'h13: out_byte = 8'h82; 8'h14: out_byte = 8'h9b; 8'h15: out_byte = 8'h2f; 8'h16: out_byte = 8'hff; 8'h17: out_byte = 8'h87;
      8'h18: out_byte = 8'h34; 8'h19: out_byte = 8'h8e; 8'h1a: out_byte = 8'h43; 8'h1b: out_byte = 8'h44; 8'h1c: out_byte = 8'hc4; 8'h1d: out_byte = 8'hde; 8'h1e: out_byte = 8'he9; 8'h1f: out_byte = 8'hcb;
      8'h20: out_byte = 8'h54; 8'h21: out_byte = 8'h7b; 8'h22: out_byte = 8'h94; 8'h23: out_byte = 8'h32; 8'h24: out_byte = 8'ha6; 8'h25: out_byte = 8'hc2; 8'h26: out_byte = 8'h23; 8'h27: out_byte = 8'h3d;
      8'h28: out_byte = 8'hee; 8'h29: out_byte = 8'h4c; 8'h2a: out_byte = 8'h95; 8'h2b: out_byte = 8'h0b; 8'h2c: out_byte = 8'h42; 8'h2d: out_byte = 8'hfa; 8'h2e: out_byte = 8'hc3; 8'h2f: out_byte = 8'h4e;
      8'h30: out_byte = 8'h08; 8'h31: out_byte = 8'h2e; 8'h32: out_byte = 8'ha1; 8'h33: out_byte = 8'h66; 8'h34: out_byte = 8'h28; 8'h35: out_byte = 8'hd9; 8'h36: out_byte = 8'h24; 8'h37: out_byte = 8'hb2;
      8'h38: out_byte = 8'h76; 8'h39: out_byte = 8'h5b; 8'h3a: out_byte = 8'ha2; 8'h3b: out_byte = 8'h49; 8'h3c: out_byte = 8'h6d; 8'h3d: out_byte = 8'h8b; 8'h3e: out_byte = 8'hd1; 8'h3f: out_byte = 8'h25;
      8'h40: out_byte = 8'h72; 8'h41: out_byte = 8'hf8; 8'h42: out_byte = 8'hf6; 8'h43: out_byte = 8'h64; 8'h44: out_byte = 8'h86; 8'h45: out_byte = 8'h68; 8'h46: out_byte = 8'h98; 8'h47: out_byte = 8'h16;
      8'h48: out_byte = 8'hd4; 8'h49: out_byte = 8'ha4; 8'h4a: out_byte = 8'h5c; 8'h4b: out_byte = 8'hcc; 8'h4c: out_byte = 8'h5d; 8'h4d: out_byte = 8'h65; 8'h4e: out_byte = 8'hb6; 8'h4f: out_byte = 8'h92;
      8'h50: out_byte = 8'h6c; 8'h51: out_byte = 8'h70; 8'h52: out_byte = 8'h48; 8'h53: out_byte = 8'h50; 8'h54: out_byte = 8'hfd; 8'h55: out_byte = 8'hed; 8'h56: out_byte = 8'hb9; 8'h57: out_byte = 8'hda;
      8'h58: out_byte = 8'h5e; 8'h59: out_byte = 8'h15; 8'h5a: out_byte = 8'h46; 8'h5b: out_byte = 8'h57; 8'h5c: out_byte = 8'ha7; 8'h5d: out_byte = 8'h8d; 8'h5e: out_byte = 8'h9d; 8'h5f: out_byte = 8'h84;
      8'h60: out_byte = 8'h90; 8'h61: out_byte = 8'hd8; 8'h62: out_byte = 8'hab; 8'h63: out_byte = 8'h00; 8'h64: out_byte = 8'h8c; 8'h65: out_byte = 8'hbc; 8'h66: out_byte = 8'hd3; 8'h67: out_byte = 8'h0a;
      8'h68: out_byte = 8'hf7; 8'h69: out_byte = 8'he4; 8'h6a: out_byte = 8'h58; 8'h6b: out_byte = 8'h05; 8'h6c: out_byte = 8'hb8; 8'h6d: out_byte = 8'hb3; 8'h6e: out_byte = 8'h45; 8'h6f: out_byte = 8'h06;
      8'h70: out_byte = 8'hd0; 8'h71: out_byte = 8'h2c; 8'h72: out_byte = 8'h1e; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'hca; 8'h75: out_byte = 8'h3f; 8'h76: out_byte = 8'h0f; 8'h77: out_byte = 8'h02;
      8'h78: out_byte = 8'hc1; 8'h79: out_byte = 8'haf; 8'h7a: out_byte = 8'hbd; 8'h7b: out_byte = 8'h03; 8'h7c: out_byte = 8'h01; 8'h7d: out_byte = 8'h13; 8'h7e: out_byte = 8'h8a; 8'h7f: out_byte = 8'h6b;
      8'h80: out_byte = 8'h3a; 8'h81: out_byte = 8'h91; 8'h82: out_byte = 8'h11; 8'h83: out_byte = 8'h41; 8'h84: out_byte = 8'h4f; 8'h85: out_byte = 8'h67; 8'h86: out_byte = 8'hdc; 8'h87: out_byte = 8'hea;
      8'h88: out_byte = 8'h97; 8'h89: out_byte = 8'hf2; 8'h8a: out_byte = 8'hcf; 8'h8b: out_byte = 8'hce; 8'h8c: out_byte = 8'hf0; 8'h8d: out_byte = 8'hb4; 8'h8e: out_byte = 8'he6; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h96; 8'h91: out_byte = 8'hac; 8'h92: out_byte = 8'h74; 8'h93: out_byte = 8'h22; 8'h94: out_byte = 8'he7; 8'h95: out_byte = 8'had; 8'h96: out_byte = 8'h35; 8'h97: out_byte = 8'h85;
      8'h98: out_byte = 8'he2; 8'h99: out_byte = 8'hf9; 8'h9a: out_byte = 8'h37; 8'h9b: out_byte = 8'he8; 8'h9c: out_byte = 8'h1c; 8'h9d: out_byte = 8'h75; 8'h9e: out_byte = 8'hdf; 8'h9f: out_byte = 8'h6e;
      8'ha0: out_byte = 8'h47; 8'ha1: out_byte = 8'hf1; 8'ha2: out_byte = 8'h1a; 8'ha3: out_byte = 8'h71; 8'ha4: out_byte = 8'h1d; 8'ha5: out_byte = 8'h29; 8'ha6: out_byte = 8'hc5; 8'ha7: out_byte = 8'h89;
      8'ha8: out_byte = 8'h6f; 8'ha9: out_byte = 8'hb7; 8'haa: out_byte = 8'h62; 8'hab: out_byte = 8'h0e; 8'hac: out_byte = 8'haa; 8'had: out_byte = 8'h18; 8'hae: out_byte = 8'hbe; 8'haf: out_byte = 8'h1b;
      8'hb0: out_byte = 8'hfc; 8'hb1: out_byte = 8'h56; 8'hb2: out_byte = 8'h3e; 8'hb3: out_byte = 8'h4b; 8'hb4: out_byte = 8'hc6; 8'hb5: out_byte = 8'hd2; 8'hb6: out_byte = 8'h79; 8'hb7: out_byte = 8'h20;
      8'hb8: out_byte = 8'h9a; 8'hb9: out_byte = 8'hdb; 8'hba: out_byte = 8'hc0; 8'hbb: out_byte = 8'hfe; 8'hbc: out_byte = 8'h78; 8'hbd: out_byte = 8'hcd; 8'hbe: out_byte = 8'h5a; 8'hbf: out_byte = 8'hf4;
      8'hc0: out_byte = 8'h1f; 8'hc1: out_byte = 8'hdd; 8'hc2: out_byte = 8'ha8; 8'hc3: out_byte = 8'h33; 8'hc4: out_byte = 8'h88; 8'hc5: out_byte = 8'h07; 8'hc6: out_byte = 8'hc7; 8'hc7: out_byte = 8'h31;
      8'hc8: out_byte = 8'hb1; 8'hc9: out_byte = 8'h12; 8'hca: out_byte = 8'h10; 8'hcb: out_byte = 8'h59; 8'hcc: out_byte = 8'h27; 8'hcd: out_byte = 8'h80; 8'hce: out_byte = 8'hec; 8'hcf: out_byte = 8'h5f;
      8'hd0: out_byte = 8'h60; 8'hd1: out_byte = 8'h51; 8'hd2: out_byte = 8'h7f; 8'hd3: out_byte = 8'ha9; 8'hd4: out_byte = 8'h19; 8'hd5: out_byte = 8'hb5; 8'hd6: out_byte = 8'h4a; 8'hd7: out_byte = 8'h0d;
      8'hd8: out_byte = 8'h2d; 8'hd9: out_byte = 8'he5; 8'hda: out_byte = 8'h7a; 8'hdb: out_byte = 8'h9f; 8'hdc: out_byte = 8'h93; 8'hdd: out_byte = 8'hc9; 8'hde: out_byte = 8'h9c; 8'hdf: out_byte = 8'hef;
      8'he0: out_byte = 8'ha0; 8'he1: out_byte = 8'he0; 8'he2: out_byte = 8'h3b; 8'he3: out_byte = 8'h4d; 8'he4: out_byte = 8'hae; 8'he5: out_byte = 8'h2a; 8'he6: out_byte = 8'hf5; 8'he7: out_byte = 8'hb0;
      8'he8: out_byte = 8'hc8; 8'he9: out_byte = 8'heb; 8'hea: out_byte = 8'hbb; 8'heb: out_byte = 8'h3c; 8'hec: out_byte = 8'h83; 8'hed: out_byte = 8'h53; 8'hee: out_byte = 8'h99; 8'hef: out_byte = 8'h61;
      8'hf0: out_byte = 8'h17; 8'hf1: out_byte = 8'h2b; 8'hf2: out_byte = 8'h04; 8'hf3: out_byte = 8'h7e; 8'hf4: out_byte = 8'hba; 8'hf5: out_byte = 8'h77; 8'hf6: out_byte = 8'hd6; 8'hf7: out_byte = 8'h26;
      8'hf8: out_byte = 8'he1; 8'hf9: out_byte = 8'h69; 8'hfa: out_byte = 8'h14; 8'hfb: out_byte = 8'h63; 8'hfc: out_byte = 8'h55; 8'hfd: out_byte = 8'h21; 8'hfe: out_byte = 8'h0c; 8'hff: out_byte = 8'h7d;
      default: out_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | inv_sub_bytes_iter - iterative AES InvSubBytes, BYTES_PER_CYCLE/clk.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] data_out
);

  localparam int               GROUPS   = AES_BYTES / BYTES_PER_CYCLE;
  localparam int               CNT_W    = cnt_width(BYTES_PER_CYCLE);
  localparam int               GRP_W    = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

  if (!(BYTES_PER_CYCLE inside {1, 2, 4, 8, 16})) begin : g_bad_bpc
    $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_e                  state;
  state_e                  state_next;
  logic [CNT_W-1:0]        cnt;
  logic [AES_STATE_W-1:0]  state_data;
  logic [GRP_W-1:0]        grp_in;
  logic [GRP_W-1:0]        grp_out;
  logic                    accept;
  logic                    last_grp;

  assign accept   = in_valid & in_ready;
  assign last_grp = (cnt == LAST_CNT);
  assign data_out = state_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last_grp) state_next = DONE;
      DONE:    if (out_ready) state_next = in_valid ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // in_ready in DONE follows out_ready combinationally so a new state can
  // be taken on the same edge the result leaves.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    grp_in = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (cnt == CNT_W'(g)) grp_in = state_data[g*GRP_W +: GRP_W];
    end
  end

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    inv_sbox u_inv_sbox (
      .in_byte  (grp_in[8*l +: 8]),
      .out_byte (grp_out[8*l +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      state_data <= '0;
    end else if (accept) begin
      cnt        <= '0;
      state_data <= data_in;
    end else if (state == BUSY) begin
      for (int g = 0; g < GROUPS; g++) begin
        if (cnt == CNT_W'(g)) state_data[g*GRP_W +: GRP_W] <= grp_out;
      end
      cnt <= last_grp ? '0 : cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_sub_bytes_iter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for inv_sub_bytes_iter: one instance per legal BYTES_PER_CYCLE,
// reference built from GF(2^8) arithmetic rather than a lookup table.
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst_n;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready;
  logic [127:0] data_in  [5];
  logic [127:0] data_out [5];

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  // Instance k runs with BYTES_PER_CYCLE = 2**k; k=2 is the default BPC=4.
  for (genvar k = 0; k < 5; k++) begin : g_dut
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .data_in   (data_in[k]),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .data_out  (data_out[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) r = 8'(y);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] s = b;
    logic [7:0] r = b;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isbox_t[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_t[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [127:0] d);
    int n = 0;
    in_valid[k] = 1'b1;
    data_in[k]  = d;
    while (in_ready[k] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("accept_timeout", 128'(n < 50), 128'd1);
    tick();
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_out(input int k, output int lat);
    lat = 0;
    while (out_valid[k] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic transact(input int k, input logic [127:0] d, input logic [127:0] exp, input string tag);
    int lat;
    send(k, d);
    wait_out(k, lat);
    check({tag, "_latency"}, 128'(lat), 128'(16 >> k));
    check({tag, "_data"}, data_out[k], exp);
    out_ready[k] = 1'b1;
    tick();
    out_ready[k] = 1'b0;
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] held;
    logic [127:0] v [3];
    int           stamp [3];
    int           idx;
    int           got;
    int           cyc;
    int           lat;
    logic         acc;
    logic         seen_valid;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    for (int k = 0; k < 5; k++) data_in[k] = '0;

    for (int b = 0; b < 256; b++) begin
      sbox_t[b] = affine(ginv(8'(b)));
      isbox_t[sbox_t[b]] = 8'(b);
    end

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_data_out", data_out[2], 128'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 128'(in_ready), 128'h1f);
    check("rst_idle_out_valid", 128'(out_valid), 128'd0);

    // Known vector from the FIPS-197 S-box
    transact(2, {96'd0, 32'hed167c63}, {{12{8'h52}}, 32'h53ff0100}, "known_vec");

    // Random states on every lane width
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 256; n++) begin
        x = rand128();
        transact(k, x, inv_sub(x), $sformatf("rand_bpc%0d", 1 << k));
      end
    end

    // Round trip through the forward S-box
    for (int n = 0; n < 16; n++) begin
      x = rand128();
      transact(2, sub(x), x, "round_trip");
    end

    // Backpressure in DONE
    x = rand128();
    send(2, x);
    wait_out(2, lat);
    held = data_out[2];
    check("bp_data", held, inv_sub(x));
    in_valid[2] = 1'b1;
    data_in[2]  = rand128();
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp_stable", data_out[2], held);
      check("bp_out_valid", 128'(out_valid[2]), 128'd1);
      check("bp_in_ready", 128'(in_ready[2]), 128'd0);
    end
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    tick();
    out_ready[2] = 1'b0;
    check("bp_release_out_valid", 128'(out_valid[2]), 128'd0);
    check("bp_release_in_ready", 128'(in_ready[2]), 128'd1);
    seen_valid = 1'b0;
    repeat (6) begin
      tick();
      seen_valid = seen_valid | out_valid[2];
    end
    check("bp_single_transfer", 128'(seen_valid), 128'd0);

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) v[i] = rand128();
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    data_in[2]   = v[0];
    idx = 0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 100) begin
      if (out_valid[2]) begin
        check("b2b_data", data_out[2], inv_sub(v[got]));
        if (got < 2) check("b2b_same_cycle_accept", 128'(in_ready[2]), 128'd1);
        stamp[got] = cyc;
        got++;
      end
      acc = in_valid[2] & in_ready[2];
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 3) data_in[2] = v[idx];
        else in_valid[2] = 1'b0;
      end
    end
    out_ready[2] = 1'b0;
    check("b2b_count", 128'(got), 128'd3);
    check("b2b_gap01", 128'(stamp[1] - stamp[0]), 128'd5);
    check("b2b_gap12", 128'(stamp[2] - stamp[1]), 128'd5);
    check("b2b_idle_after", 128'(out_valid[2]), 128'd0);

    // Reset during the second BUSY cycle
    x = rand128();
    send(2, x);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 128'(out_valid[2]), 128'd0);
    check("midrst_data_out", data_out[2], 128'd0);
    check("midrst_in_ready", 128'(in_ready[2]), 128'd1);
    seen_valid = 1'b0;
    repeat (6) begin
      tick();
      seen_valid = seen_valid | out_valid[2];
    end
    check("midrst_no_pulse", 128'(seen_valid), 128'd0);
    x = rand128();
    transact(2, x, inv_sub(x), "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
